// File: rtl/reg_bank.sv
// reg_bank: 32-entry general-purpose register storage feeding the read mux.
//   Clk, Rst_n     : rising-edge clock, asynchronous active-low reset
//   Awr, Din, WrEn : single write port; a write is taken when WrEn && WrReady
//   WrReady        : bank accepts writes (low only while the clear sweep runs)
//   Clr            : clear request, sampled only in IDLE
//   Busy, ClrDone  : sweep in progress / one-cycle sweep-finished pulse
//   Dout0..Dout31  : register contents, one-to-one to read-mux inputs
// Parameters: WIDTH (data width), R0_ZERO (1: register 0 is constant zero).
module reg_bank #(
  parameter int WIDTH   = 32,
  parameter int R0_ZERO = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       Awr,
  input  logic [WIDTH-1:0] Din,
  input  logic             WrEn,
  output logic             WrReady,
  input  logic             Clr,
  output logic             Busy,
  output logic             ClrDone,
  output logic [WIDTH-1:0] Dout0,
  output logic [WIDTH-1:0] Dout1,
  output logic [WIDTH-1:0] Dout2,
  output logic [WIDTH-1:0] Dout3,
  output logic [WIDTH-1:0] Dout4,
  output logic [WIDTH-1:0] Dout5,
  output logic [WIDTH-1:0] Dout6,
  output logic [WIDTH-1:0] Dout7,
  output logic [WIDTH-1:0] Dout8,
  output logic [WIDTH-1:0] Dout9,
  output logic [WIDTH-1:0] Dout10,
  output logic [WIDTH-1:0] Dout11,
  output logic [WIDTH-1:0] Dout12,
  output logic [WIDTH-1:0] Dout13,
  output logic [WIDTH-1:0] Dout14,
  output logic [WIDTH-1:0] Dout15,
  output logic [WIDTH-1:0] Dout16,
  output logic [WIDTH-1:0] Dout17,
  output logic [WIDTH-1:0] Dout18,
  output logic [WIDTH-1:0] Dout19,
  output logic [WIDTH-1:0] Dout20,
  output logic [WIDTH-1:0] Dout21,
  output logic [WIDTH-1:0] Dout22,
  output logic [WIDTH-1:0] Dout23,
  output logic [WIDTH-1:0] Dout24,
  output logic [WIDTH-1:0] Dout25,
  output logic [WIDTH-1:0] Dout26,
  output logic [WIDTH-1:0] Dout27,
  output logic [WIDTH-1:0] Dout28,
  output logic [WIDTH-1:0] Dout29,
  output logic [WIDTH-1:0] Dout30,
  output logic [WIDTH-1:0] Dout31
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rd [32];
  logic [WIDTH-1:0] mem_d [32];
  logic             wr_fire;

  // Control FSM and sweep counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Clr) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        // Counter wraps to 0 as register 31 is cleared.
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy    = (state_q == SWEEP);
  assign ClrDone = (state_q == DONE);
  assign WrReady = ~Busy;

  assign wr_fire = WrEn && WrReady && !((R0_ZERO != 0) && (Awr == 5'd0));

  // Next value of every register: hold, write port, then sweep clear.
  // Writes and sweep never coincide because WrReady is low during SWEEP.
  always_comb begin
    for (int unsigned k = 0; k < 32; k++) mem_d[k] = rd[k];
    if (wr_fire) mem_d[Awr] = Din;
    if (state_q == SWEEP) mem_d[cnt_q] = '0;
  end

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if ((i == 0) && (R0_ZERO != 0)) begin : g_zero
      assign rd[i] = '0;
    end else begin : g_flop
      logic [WIDTH-1:0] val_q;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) val_q <= '0;
        else        val_q <= mem_d[i];
      end
      assign rd[i] = val_q;
    end
  end

  assign Dout0  = rd[0];
  assign Dout1  = rd[1];
  assign Dout2  = rd[2];
  assign Dout3  = rd[3];
  assign Dout4  = rd[4];
  assign Dout5  = rd[5];
  assign Dout6  = rd[6];
  assign Dout7  = rd[7];
  assign Dout8  = rd[8];
  assign Dout9  = rd[9];
  assign Dout10 = rd[10];
  assign Dout11 = rd[11];
  assign Dout12 = rd[12];
  assign Dout13 = rd[13];
  assign Dout14 = rd[14];
  assign Dout15 = rd[15];
  assign Dout16 = rd[16];
  assign Dout17 = rd[17];
  assign Dout18 = rd[18];
  assign Dout19 = rd[19];
  assign Dout20 = rd[20];
  assign Dout21 = rd[21];
  assign Dout22 = rd[22];
  assign Dout23 = rd[23];
  assign Dout24 = rd[24];
  assign Dout25 = rd[25];
  assign Dout26 = rd[26];
  assign Dout27 = rd[27];
  assign Dout28 = rd[28];
  assign Dout29 = rd[29];
  assign Dout30 = rd[30];
  assign Dout31 = rd[31];

endmodule
